// File: rtl/avalon_st_stats_mon.sv
// Avalon-ST statistics monitor: counts good/bad/malformed frames, bytes,
// active cycles, min/max frame length and a four-bin length histogram.
// Stats are read and the run is controlled through a small CSR block.
module avalon_st_stats_mon #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3,
    parameter int ERR_W   = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         csr_address,
    input  logic               csr_write,
    input  logic               csr_read,
    input  logic [31:0]        csr_writedata,
    output logic [31:0]        csr_readdata,
    output logic               csr_readdatavalid,
    input  logic [DATA_W-1:0]  st_data,
    input  logic               st_valid,
    input  logic               st_sop,
    input  logic               st_eop,
    input  logic [EMPTY_W-1:0] st_empty,
    input  logic [ERR_W-1:0]   st_error,
    output logic               st_ready,
    output logic               mon_active,
    output logic               mon_done,
    output logic               mon_error
);

    localparam logic [31:0] BPB = 32'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, ACTIVE = 2'd2, DONE = 2'd3} state_t;

    state_t             state;
    logic               bp_mode;
    logic               phase;
    logic               in_pkt;
    logic [15:0]        beat_cnt;
    logic [31:0]        target;
    logic [CNT_W-1:0]   good_cnt;
    logic [CNT_W-1:0]   bad_cnt;
    logic [CNT_W-1:0]   framing_cnt;
    logic [CNT_W-1:0]   hist_cnt [4];
    logic [63:0]        bytes_cnt;
    logic [63:0]        cycles_cnt;
    logic [15:0]        min_len;
    logic [15:0]        max_len;
    logic [ERR_W-1:0]   last_err;
    logic [31:0]        bytes_hi_shadow;
    logic [31:0]        cycles_hi_shadow;

    logic               start;
    logic               stop;
    logic               accept;
    logic               beat_go;
    logic               framing_inc;
    logic               frame_done;
    logic               frame_bad;
    logic [16:0]        frame_beats;
    logic [31:0]        frame_bytes_full;
    logic [15:0]        frame_len;
    logic [1:0]         hist_idx;
    logic [63:0]        total_next;
    logic               target_hit;
    logic [64:0]        bytes_sum;
    logic [63:0]        bytes_next;
    logic               unused_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The payload itself is never inspected, only the framing sidebands.
    assign unused_bits = ^st_data;

    assign start      = csr_write && (csr_address == 8'h00) && csr_writedata[0];
    assign stop       = csr_write && (csr_address == 8'h00) && csr_writedata[1];
    assign st_ready   = reset_n && !(bp_mode && phase);
    assign accept     = st_valid && st_ready;
    assign mon_active = (state == ACTIVE);
    assign mon_done   = (state == DONE);

    // Classify the current beat and work out the length of a frame that ends on it.
    always_comb begin
        framing_inc = 1'b0;
        frame_done  = 1'b0;
        frame_beats = 17'd0;
        beat_go     = accept && !start &&
                      (((state == ACTIVE) && !stop) || ((state == ARMED) && st_sop));
        if (beat_go) begin
            if (st_sop) begin
                framing_inc = in_pkt;
                frame_done  = st_eop;
                frame_beats = 17'd1;
            end else if (!in_pkt) begin
                framing_inc = 1'b1;
            end else begin
                frame_done  = st_eop;
                frame_beats = 17'(beat_cnt) + 17'd1;
            end
        end
        frame_bytes_full = 32'(frame_beats) * BPB - 32'(st_empty);
        frame_len        = (frame_bytes_full > 32'h0000_FFFF) ? 16'hFFFF : frame_bytes_full[15:0];
        frame_bad        = (st_error != '0);
        if (frame_len <= 16'd64)
            hist_idx = 2'd0;
        else if (frame_len <= 16'd255)
            hist_idx = 2'd1;
        else if (frame_len <= 16'd1518)
            hist_idx = 2'd2;
        else
            hist_idx = 2'd3;
        total_next = 64'(good_cnt) + 64'(bad_cnt) + 64'd1;
        target_hit = frame_done && (target != 32'd0) && (total_next == 64'(target));
        bytes_sum  = {1'b0, bytes_cnt} + 65'(frame_len);
        bytes_next = bytes_sum[64] ? '1 : bytes_sum[63:0];
    end

    // Run control state machine, framing tracker and all statistics counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bp_mode     <= 1'b0;
            phase       <= 1'b0;
            in_pkt      <= 1'b0;
            beat_cnt    <= 16'd0;
            target      <= 32'd0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            framing_cnt <= '0;
            for (int i = 0; i < 4; i++) hist_cnt[i] <= '0;
            bytes_cnt   <= 64'd0;
            cycles_cnt  <= 64'd0;
            min_len     <= 16'hFFFF;
            max_len     <= 16'd0;
            last_err    <= '0;
            mon_error   <= 1'b0;
        end else begin
            phase <= bp_mode ? !phase : 1'b0;
            if (csr_write && (csr_address == 8'h00))
                bp_mode <= csr_writedata[2];
            if (csr_write && (csr_address == 8'h01))
                target <= csr_writedata;
            if (start) begin
                state       <= ARMED;
                in_pkt      <= 1'b0;
                beat_cnt    <= 16'd0;
                good_cnt    <= '0;
                bad_cnt     <= '0;
                framing_cnt <= '0;
                for (int i = 0; i < 4; i++) hist_cnt[i] <= '0;
                bytes_cnt   <= 64'd0;
                cycles_cnt  <= 64'd0;
                min_len     <= 16'hFFFF;
                max_len     <= 16'd0;
                mon_error   <= 1'b0;
            end else begin
                if (state == ACTIVE && !(&cycles_cnt))
                    cycles_cnt <= cycles_cnt + 64'd1;
                if (state == ACTIVE && stop) begin
                    state     <= DONE;
                    mon_error <= (bad_cnt != '0) || (framing_cnt != '0);
                end
                if (beat_go) begin
                    if (state == ARMED)
                        state <= ACTIVE;
                    if (framing_inc)
                        framing_cnt <= sat_inc(framing_cnt);
                    if (st_sop) begin
                        in_pkt   <= !st_eop;
                        beat_cnt <= 16'd1;
                    end else if (in_pkt) begin
                        if (st_eop)
                            in_pkt <= 1'b0;
                        else if (!(&beat_cnt))
                            beat_cnt <= beat_cnt + 16'd1;
                    end
                    if (frame_done) begin
                        if (frame_bad)
                            bad_cnt <= sat_inc(bad_cnt);
                        else
                            good_cnt <= sat_inc(good_cnt);
                        bytes_cnt          <= bytes_next;
                        hist_cnt[hist_idx] <= sat_inc(hist_cnt[hist_idx]);
                        last_err           <= st_error;
                        if (frame_len < min_len)
                            min_len <= frame_len;
                        if (frame_len > max_len)
                            max_len <= frame_len;
                        if (target_hit) begin
                            state     <= DONE;
                            mon_error <= (bad_cnt != '0) || frame_bad ||
                                         (framing_cnt != '0) || framing_inc;
                        end
                    end
                end
            end
        end
    end

    // Registered CSR read path; reading a 64-bit low word snapshots its high word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csr_readdata      <= 32'd0;
            csr_readdatavalid <= 1'b0;
            bytes_hi_shadow   <= 32'd0;
            cycles_hi_shadow  <= 32'd0;
        end else begin
            csr_readdatavalid <= csr_read;
            if (csr_read) begin
                case (csr_address)
                    8'h00:   csr_readdata <= {29'd0, bp_mode, 2'b00};
                    8'h01:   csr_readdata <= target;
                    8'h02:   csr_readdata <= 32'(good_cnt);
                    8'h03:   csr_readdata <= 32'(bad_cnt);
                    8'h04:   csr_readdata <= 32'(framing_cnt);
                    8'h05:   csr_readdata <= bytes_cnt[31:0];
                    8'h06:   csr_readdata <= bytes_hi_shadow;
                    8'h07:   csr_readdata <= cycles_cnt[31:0];
                    8'h08:   csr_readdata <= cycles_hi_shadow;
                    8'h09:   csr_readdata <= 32'(min_len);
                    8'h0A:   csr_readdata <= 32'(max_len);
                    8'h0B:   csr_readdata <= 32'(hist_cnt[0]);
                    8'h0C:   csr_readdata <= 32'(hist_cnt[1]);
                    8'h0D:   csr_readdata <= 32'(hist_cnt[2]);
                    8'h0E:   csr_readdata <= 32'(hist_cnt[3]);
                    8'h0F:   csr_readdata <= 32'({state, in_pkt, last_err});
                    default: csr_readdata <= 32'd0;
                endcase
                if (csr_address == 8'h05)
                    bytes_hi_shadow <= bytes_cnt[63:32];
                if (csr_address == 8'h07)
                    cycles_hi_shadow <= cycles_cnt[63:32];
            end
        end
    end

endmodule

// File: tb/tb_avalon_st_stats_mon.sv
// Directed testbench for avalon_st_stats_mon with hand-computed expectations.
module tb_avalon_st_stats_mon;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  csr_address;
    logic        csr_write;
    logic        csr_read;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        csr_readdatavalid;
    logic [63:0] st_data;
    logic        st_valid;
    logic        st_sop;
    logic        st_eop;
    logic [2:0]  st_empty;
    logic [5:0]  st_error;
    logic        st_ready;
    logic        mon_active;
    logic        mon_done;
    logic        mon_error;

    int checkCount = 0;
    int passCount  = 0;

    avalon_st_stats_mon dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .csr_address       (csr_address),
        .csr_write         (csr_write),
        .csr_read          (csr_read),
        .csr_writedata     (csr_writedata),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .st_data           (st_data),
        .st_valid          (st_valid),
        .st_sop            (st_sop),
        .st_eop            (st_eop),
        .st_empty          (st_empty),
        .st_error          (st_error),
        .st_ready          (st_ready),
        .mon_active        (mon_active),
        .mon_done          (mon_done),
        .mon_error         (mon_error)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally the result
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic csrWrite(input logic [7:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
    endtask

    task automatic csrRead(input logic [7:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        @(negedge clk);
        csr_read    = 1'b0;
        d           = csr_readdata;
    endtask

    task automatic checkCsr(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        csrRead(a, d);
        checkOutput(tag, 64'(d), 64'(exp));
    endtask

    // Drive one beat and hold it until the sink accepts it (bounded wait)
    task automatic applyStimulus(input logic sop, input logic eop,
                                 input logic [2:0] empty, input logic [5:0] err);
        bit accepted;
        accepted = 1'b0;
        st_valid = 1'b1;
        st_sop   = sop;
        st_eop   = eop;
        st_empty = empty;
        st_error = err;
        st_data  = {$urandom, $urandom};
        for (int i = 0; i < 8 && !accepted; i++) begin
            if (st_ready) accepted = 1'b1;
            @(negedge clk);
        end
        if (!accepted) checkOutput("beat_accept", 64'd0, 64'd1);
    endtask

    task automatic sendFrame(input int nbeats, input logic [2:0] empty, input logic [5:0] err);
        for (int b = 0; b < nbeats; b++)
            applyStimulus(b == 0, b == nbeats - 1, (b == nbeats - 1) ? empty : 3'd0, err);
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
    endtask

    // Guard against a hung run
    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] rd;
        reset_n = 1'b0; csr_address = 8'h00; csr_write = 1'b0; csr_read = 1'b0;
        csr_writedata = 32'd0; st_data = 64'd0; st_valid = 1'b0; st_sop = 1'b0;
        st_eop = 1'b0; st_empty = 3'd0; st_error = 6'd0;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("rst_ready",  64'(st_ready), 64'd0);
        checkOutput("rst_active", 64'(mon_active), 64'd0);
        checkOutput("rst_done",   64'(mon_done), 64'd0);
        checkOutput("rst_error",  64'(mon_error), 64'd0);
        checkOutput("rst_rdv",    64'(csr_readdatavalid), 64'd0);
        checkOutput("rst_rdata",  64'(csr_readdata), 64'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("rel_ready", 64'(st_ready), 64'd1);
        csrRead(8'h09, rd);
        checkOutput("rdv_after_read", 64'(csr_readdatavalid), 64'd1);
        checkOutput("rst_min", 64'(rd), 64'hFFFF);
        checkCsr("rst_target", 8'h01, 32'd0);
        checkCsr("rst_status", 8'h0F, 32'd0);

        $display("[TB] three 64-byte frames to target");
        csrWrite(8'h01, 32'd3);
        csrWrite(8'h00, 32'd1);
        checkCsr("armed_status", 8'h0F, 32'h080);
        sendFrame(8, 3'd0, 6'd0);
        checkOutput("active_flag", 64'(mon_active), 64'd1);
        sendFrame(8, 3'd0, 6'd0);
        sendFrame(8, 3'd0, 6'd0);
        checkOutput("tgt_done",  64'(mon_done), 64'd1);
        checkOutput("tgt_error", 64'(mon_error), 64'd0);
        sendFrame(8, 3'd0, 6'd0);
        checkCsr("tgt_good",   8'h02, 32'd3);
        checkCsr("tgt_bad",    8'h03, 32'd0);
        checkCsr("tgt_bytes",  8'h05, 32'd192);
        checkCsr("tgt_bin0",   8'h0B, 32'd3);
        checkCsr("tgt_min",    8'h09, 32'd64);
        checkCsr("tgt_max",    8'h0A, 32'd64);
        checkCsr("tgt_cycles", 8'h07, 32'd23);
        checkCsr("tgt_status", 8'h0F, 32'h180);
        checkCsr("ctrl_read",  8'h00, 32'd0);

        $display("[TB] errored 61-byte frame then stop");
        csrWrite(8'h01, 32'd0);
        csrWrite(8'h00, 32'd1);
        sendFrame(8, 3'd3, 6'h02);
        checkCsr("err_bad",    8'h03, 32'd1);
        checkCsr("err_good",   8'h02, 32'd0);
        checkCsr("err_bytes",  8'h05, 32'd61);
        checkCsr("err_bin0",   8'h0B, 32'd1);
        checkCsr("err_status", 8'h0F, 32'h102);
        checkOutput("err_pre_stop", 64'(mon_error), 64'd0);
        csrWrite(8'h00, 32'd2);
        checkOutput("stop_done",  64'(mon_done), 64'd1);
        checkOutput("stop_error", 64'(mon_error), 64'd1);
        checkCsr("stop_status", 8'h0F, 32'h182);

        $display("[TB] framing error then 1519-byte frame");
        csrWrite(8'h00, 32'd1);
        checkOutput("start_clr_err", 64'(mon_error), 64'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 6'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 6'd0);
        sendFrame(190, 3'd1, 6'd0);
        checkCsr("frm_framing", 8'h04, 32'd1);
        checkCsr("frm_good",    8'h02, 32'd1);
        checkCsr("frm_bin3",    8'h0E, 32'd1);
        checkCsr("frm_bin2",    8'h0D, 32'd0);
        checkCsr("frm_max",     8'h0A, 32'd1519);
        checkCsr("frm_bytes",   8'h05, 32'd1519);
        applyStimulus(1'b0, 1'b0, 3'd0, 6'd0);
        st_valid = 1'b0;
        checkCsr("frm_stray", 8'h04, 32'd2);
        csrWrite(8'h00, 32'd2);
        checkOutput("frm_mon_error", 64'(mon_error), 64'd1);

        $display("[TB] backpressure mode");
        csrWrite(8'h00, 32'd5);
        checkOutput("bp_ready0", 64'(st_ready), 64'd1);
        @(negedge clk);
        checkOutput("bp_ready1", 64'(st_ready), 64'd0);
        @(negedge clk);
        checkOutput("bp_ready2", 64'(st_ready), 64'd1);
        sendFrame(16, 3'd0, 6'd0);
        checkCsr("bp_bytes", 8'h05, 32'd128);
        checkCsr("bp_good",  8'h02, 32'd1);
        checkCsr("bp_ctrl",  8'h00, 32'd4);
        csrWrite(8'h00, 32'd0);

        $display("[TB] single-beat frame and 64-bit byte counter");
        csrWrite(8'h00, 32'd1);
        sendFrame(1, 3'd0, 6'd0);
        checkCsr("single_good", 8'h02, 32'd1);
        checkCsr("single_min",  8'h09, 32'd8);
        sendFrame(8, 3'd0, 6'd0);
        force dut.bytes_cnt = 64'h0000_0000_FFFF_FFC0;
        @(negedge clk);
        release dut.bytes_cnt;
        checkCsr("shadow_lo0", 8'h05, 32'hFFFF_FFC0);
        sendFrame(8, 3'd0, 6'd0);
        checkCsr("shadow_hi0", 8'h06, 32'd0);
        checkCsr("shadow_lo1", 8'h05, 32'd0);
        checkCsr("shadow_hi1", 8'h06, 32'd1);
        force dut.bytes_cnt = 64'hFFFF_FFFF_FFFF_FFF0;
        @(negedge clk);
        release dut.bytes_cnt;
        sendFrame(8, 3'd0, 6'd0);
        checkCsr("sat_lo", 8'h05, 32'hFFFF_FFFF);
        checkCsr("sat_hi", 8'h06, 32'hFFFF_FFFF);

        $display("[TB] start collides with eop");
        csrWrite(8'h00, 32'd1);
        applyStimulus(1'b1, 1'b0, 3'd0, 6'd0);
        repeat (6) applyStimulus(1'b0, 1'b0, 3'd0, 6'd0);
        st_sop = 1'b0; st_eop = 1'b1; st_valid = 1'b1;
        csr_address = 8'h00; csr_writedata = 32'd1; csr_write = 1'b1;
        @(negedge clk);
        csr_write = 1'b0; st_valid = 1'b0; st_eop = 1'b0;
        checkOutput("col_active", 64'(mon_active), 64'd0);
        checkCsr("col_status", 8'h0F, 32'h080);
        checkCsr("col_good",   8'h02, 32'd0);
        checkCsr("col_bytes",  8'h05, 32'd0);

        $display("[TB] reset mid-packet");
        applyStimulus(1'b1, 1'b0, 3'd0, 6'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 6'd0);
        st_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_rst_ready",  64'(st_ready), 64'd0);
        checkOutput("mid_rst_active", 64'(mon_active), 64'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("mid_rel_ready", 64'(st_ready), 64'd1);
        checkCsr("mid_status", 8'h0F, 32'd0);
        checkCsr("mid_min",    8'h09, 32'hFFFF);
        checkCsr("mid_bogus",  8'h20, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
